// File: rtl/turn_controller_if.sv
// Board register file write port: the controller requests, the board file acknowledges.
interface turn_controller_if;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [2:0] wr_data;
  logic       wr_ack;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/turn_controller.sv
// Sequences one checkers move: piece selection, mask check, board writes over a
// req/ack port, multi-jump chains, promotion and turn bookkeeping.
module turn_controller #(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              select_pulse,
  input  logic [5:0]        cursor_loc,
  input  logic [2:0]        cursor_piece,
  input  logic [2:0]        sel_piece,
  input  logic              mask_valid,
  input  logic [63:0]       legal_mask,
  input  logic [63:0]       jump_mask,
  turn_controller_if.master wr_if,
  output logic [5:0]        sel_loc,
  output logic              sel_valid,
  output logic              turn,
  output logic [CNT_W-1:0]  turn_count,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE,
    WAIT_MASK,
    PICKED,
    WR_DST,
    WR_SRC,
    WR_CAP,
    FINISH,
    WAIT_CHAIN,
    CHAIN
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       sel_loc_q, sel_loc_d;
  logic             sel_valid_q, sel_valid_d;
  logic             turn_q, turn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       dst_q, dst_d;
  logic             is_jump_q, is_jump_d;
  logic [2:0]       piece_q, piece_d;
  logic             wr_en_q, wr_en_d;
  logic [5:0]       wr_addr_q, wr_addr_d;
  logic [2:0]       wr_data_q, wr_data_d;

  logic       cursor_own;
  logic       cursor_legal;
  logic       cursor_jump;
  logic       promote_now;
  logic [2:0] dst_data;
  logic [6:0] cap_sum;
  logic [5:0] cap_loc;
  logic [5:0] wr_addr_sel;
  logic [2:0] wr_data_sel;
  logic       end_turn;

  assign cursor_own   = (cursor_piece[1:0] != 2'b00) && (cursor_piece[2] == turn_q);
  assign cursor_legal = legal_mask[cursor_loc];
  assign cursor_jump  = jump_mask[cursor_loc];

  // Only a man crowns: red on row 7, black on row 0. A king landing there is unchanged.
  assign promote_now = (piece_q[1:0] == 2'b01) &&
                       (piece_q[2] ? (dst_q[5:3] == 3'd0) : (dst_q[5:3] == 3'd7));
  assign dst_data    = promote_now ? {piece_q[2], 2'b10} : piece_q;

  // Captured square sits midway between source and destination of a jump.
  assign cap_sum = {1'b0, sel_loc_q} + {1'b0, dst_q};
  assign cap_loc = cap_sum[6:1];

  always_comb begin
    wr_addr_sel = sel_loc_q;
    wr_data_sel = 3'b000;
    case (state_q)
      WR_DST: begin
        wr_addr_sel = dst_q;
        wr_data_sel = dst_data;
      end
      WR_CAP:  wr_addr_sel = cap_loc;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sel_loc_d   = sel_loc_q;
    sel_valid_d = sel_valid_q;
    turn_d      = turn_q;
    cnt_d       = cnt_q;
    dst_d       = dst_q;
    is_jump_d   = is_jump_q;
    piece_d     = piece_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    end_turn    = 1'b0;

    case (state_q)
      IDLE: begin
        if (select_pulse && cursor_own) begin
          sel_loc_d   = cursor_loc;
          sel_valid_d = 1'b1;
          state_d     = WAIT_MASK;
        end
      end

      WAIT_MASK: begin
        if (mask_valid) begin
          if (legal_mask == 64'd0) begin
            sel_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = PICKED;
          end
        end
      end

      PICKED: begin
        if (select_pulse) begin
          if (cursor_loc == sel_loc_q) begin
            sel_valid_d = 1'b0;
            state_d     = IDLE;
          end else if (cursor_own) begin
            sel_loc_d = cursor_loc;
            state_d   = WAIT_MASK;
          end else if (cursor_legal) begin
            dst_d     = cursor_loc;
            is_jump_d = cursor_jump;
            piece_d   = sel_piece;
            state_d   = WR_DST;
          end
        end
      end

      // First cycle of each write state leaves wr_en low, giving the idle gap
      // between consecutive writes; the request is then held until acked.
      WR_DST, WR_SRC, WR_CAP: begin
        if (!wr_en_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_sel;
          wr_data_d = wr_data_sel;
        end else if (wr_if.wr_ack) begin
          wr_en_d = 1'b0;
          case (state_q)
            WR_DST:  state_d = WR_SRC;
            WR_SRC:  state_d = is_jump_q ? WR_CAP : FINISH;
            default: state_d = FINISH;
          endcase
        end
      end

      FINISH: begin
        if (is_jump_q && !promote_now) begin
          sel_loc_d = dst_q;
          state_d   = WAIT_CHAIN;
        end else begin
          end_turn = 1'b1;
        end
      end

      WAIT_CHAIN: begin
        if (mask_valid) begin
          if (jump_mask == 64'd0) begin
            end_turn = 1'b1;
          end else begin
            state_d = CHAIN;
          end
        end
      end

      CHAIN: begin
        if (select_pulse && cursor_jump) begin
          dst_d     = cursor_loc;
          is_jump_d = 1'b1;
          piece_d   = sel_piece;
          state_d   = WR_DST;
        end
      end

      default: state_d = IDLE;
    endcase

    if (end_turn) begin
      turn_d      = ~turn_q;
      sel_valid_d = 1'b0;
      state_d     = IDLE;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_loc_q   <= 6'd0;
      sel_valid_q <= 1'b0;
      turn_q      <= 1'b0;
      cnt_q       <= '0;
      dst_q       <= 6'd0;
      is_jump_q   <= 1'b0;
      piece_q     <= 3'b000;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 6'd0;
      wr_data_q   <= 3'b000;
    end else begin
      state_q     <= state_d;
      sel_loc_q   <= sel_loc_d;
      sel_valid_q <= sel_valid_d;
      turn_q      <= turn_d;
      cnt_q       <= cnt_d;
      dst_q       <= dst_d;
      is_jump_q   <= is_jump_d;
      piece_q     <= piece_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign sel_loc       = sel_loc_q;
  assign sel_valid     = sel_valid_q;
  assign turn          = turn_q;
  assign turn_count    = cnt_q;
  assign busy          = (state_q != IDLE) && (state_q != PICKED);
  assign wr_if.wr_en   = wr_en_q;
  assign wr_if.wr_addr = wr_addr_q;
  assign wr_if.wr_data = wr_data_q;

endmodule
